// File: rtl/stage_e_muldiv.sv
// Iterative multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, one step per
// cycle, with a final sign fix. Divide-by-zero, signed overflow and ARM-mode
// divide encodings can complete in a single cycle.
module stage_e_muldiv #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             StartE,
  input  logic             FlushE,
  input  logic [2:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] ResultE
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;

  // start-cycle decode
  logic             is_div, signed_a, signed_b, sa, sb;
  logic             div_zero, ovf, early, neg_start;
  logic [WIDTH-1:0] mag_a, mag_b, early_res;

  // iteration datapath
  logic [WIDTH:0]     mul_sum, r_sh;
  logic [WIDTH-1:0]   diff, quot, rem, final_res;
  logic [2*WIDTH-1:0] acc_step, prod;

  // Decode the incoming instruction: operand magnitudes, result sign, early-out.
  always_comb begin
    is_div    = OpE[2];
    signed_a  = is_div ? ~OpE[0] : (OpE != 3'b011);
    signed_b  = is_div ? ~OpE[0] : ~OpE[1];
    sa        = signed_a & SrcAE[WIDTH-1];
    sb        = signed_b & SrcBE[WIDTH-1];
    mag_a     = sa ? -SrcAE : SrcAE;
    mag_b     = sb ? -SrcBE : SrcBE;
    div_zero  = (SrcBE == '0);
    ovf       = ~OpE[0] & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
    early     = is_div & (arm | (EARLY_OUT & (div_zero | ovf)));
    // A zero divisor gives an all-ones quotient magnitude, so the quotient
    // sign must not be applied then; the remainder always follows the dividend.
    if (!is_div)      neg_start = sa ^ sb;
    else if (OpE[1])  neg_start = sa;
    else              neg_start = (sa ^ sb) & ~div_zero;
    if (arm)          early_res = '0;
    else if (div_zero) early_res = OpE[1] ? SrcAE : '1;
    else              early_res = OpE[1] ? '0 : SrcAE;
  end

  // One multiply or divide step on the {high, low} accumulator, plus sign fix.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, b_q} & {(WIDTH+1){acc_q[0]}});
    r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = r_sh[WIDTH-1:0] - b_q;
    if (op_q[2]) begin
      if (r_sh >= {1'b0, b_q}) acc_step = {diff, acc_q[WIDTH-2:0], 1'b1};
      else                     acc_step = {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = neg_q ? -acc_step : acc_step;
    quot = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      if (op_q[1]) final_res = neg_q ? -rem : rem;
      else         final_res = neg_q ? -quot : quot;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (FlushE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (StartE) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
            b_d   = mag_b;
            op_d  = OpE;
            neg_d = neg_start;
            cnt_d = '0;
            if (early) begin
              result_d = early_res;
              done_d   = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = final_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign BusyE   = ((state_q == IDLE) & StartE & ~FlushE) | (state_q == CALC);
  assign DoneE   = done_q;
  assign ResultE = result_q;

endmodule

// File: tb/tb_stage_e_muldiv.sv
// Self-checking bench for stage_e_muldiv: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_stage_e_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, StartE, FlushE;
  logic [2:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int total = 0;
  int bad   = 0;

  stage_e_muldiv #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst_n), .arm(arm), .StartE(StartE), .FlushE(FlushE),
    .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic armm, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    if (armm && op[2]) return 32'h0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic armm, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    if (armm && op[2]) return 1;
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  // Present one instruction, hold it through DONE, check busy each cycle,
  // latency and result; then drop StartE for one idle cycle.
  task automatic do_op(input string tag, input logic armm, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, n, got;
    exp = ref_res(armm, op, a, b);
    lat = ref_lat(armm, op, a, b);
    arm = armm; OpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1; FlushE = 1'b0;
    n = 0; got = -1;
    while (got < 0 && n <= lat + 3) begin
      @(negedge clk);
      check({tag, "_busy"}, BusyE, (n < lat));
      if (DoneE) got = n;
      next_cycle();
      n++;
    end
    check({tag, "_lat"}, got, lat);
    check({tag, "_res"}, ResultE, exp);
    StartE = 1'b0;
    next_cycle();
  endtask

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  op;
    logic        am;
    int          n, d1, d2, pulses, sel;

    rst_n = 1'b0; arm = 1'b0; StartE = 1'b0; FlushE = 1'b0;
    OpE = '0; SrcAE = '0; SrcBE = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_busy", BusyE, 0);
    check("rst_done", DoneE, 0);
    check("rst_res", ResultE, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    do_op("mul_7xm3", 1'b0, 3'b000, 32'd7, 32'hFFFFFFFD);
    check("mul_7xm3_val", ResultE, 32'hFFFFFFEB);
    do_op("mulhu_max", 1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mulhu_max_val", ResultE, 32'hFFFFFFFE);

    // Reset in the middle of a calculation
    arm = 1'b0; OpE = 3'b000; SrcAE = 32'd12345; SrcBE = 32'd678; StartE = 1'b1;
    repeat (5) next_cycle();
    StartE = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_busy", BusyE, 0);
      check("midrst_done", DoneE, 0);
      check("midrst_res", ResultE, 0);
      next_cycle();
    end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DoneE) pulses++;
      next_cycle();
    end
    check("midrst_nodone", pulses, 0);
    do_op("after_rst", 1'b0, 3'b000, 32'd12345, 32'd678);

    do_op("div_m7_2", 1'b0, 3'b100, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_val", ResultE, 32'hFFFFFFFD);
    do_op("rem_m7_2", 1'b0, 3'b110, 32'hFFFFFFF9, 32'd2);
    check("rem_m7_2_val", ResultE, 32'hFFFFFFFF);
    do_op("divu_100_7", 1'b0, 3'b101, 32'd100, 32'd7);
    check("divu_100_7_val", ResultE, 32'd14);
    do_op("remu_100_7", 1'b0, 3'b111, 32'd100, 32'd7);
    check("remu_100_7_val", ResultE, 32'd2);
    do_op("div_by0", 1'b0, 3'b100, 32'hFFFFFFF9, 32'd0);
    check("div_by0_val", ResultE, 32'hFFFFFFFF);
    do_op("remu_5_0", 1'b0, 3'b111, 32'd5, 32'd0);
    check("remu_5_0_val", ResultE, 32'd5);
    do_op("div_ovf", 1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_val", ResultE, 32'h80000000);
    do_op("rem_ovf", 1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF);
    do_op("arm_div", 1'b1, 3'b101, 32'd100, 32'd7);
    do_op("arm_smull", 1'b1, 3'b001, 32'hFFFFFFF0, 32'd3);

    // Flush during a divide
    prev = ResultE;
    arm = 1'b0; OpE = 3'b100; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    pulses = 0;
    for (n = 0; n < 12; n++) begin
      if (n == 10) FlushE = 1'b1;
      if (n == 11) begin FlushE = 1'b0; StartE = 1'b0; end
      @(negedge clk);
      if (DoneE) pulses++;
      if (n == 11) check("flush_busy", BusyE, 0);
      next_cycle();
    end
    check("flush_nodone", pulses, 0);
    check("flush_res_kept", ResultE, prev);
    do_op("after_flush", 1'b0, 3'b100, 32'd1000, 32'd3);

    // Back-to-back MUL then DIVU, StartE held through the DONE cycles
    pulses = 0;
    arm = 1'b0; OpE = 3'b000; SrcAE = 32'd1234; SrcBE = 32'd5678; StartE = 1'b1;
    n = 0; d1 = -1;
    while (d1 < 0 && n < 40) begin
      @(negedge clk);
      if (DoneE) begin d1 = n; pulses++; check("b2b_done_busy", BusyE, 0); end
      next_cycle();
      n++;
    end
    check("b2b_mul_lat", d1, 33);
    check("b2b_mul_res", ResultE, ref_res(1'b0, 3'b000, 32'd1234, 32'd5678));
    OpE = 3'b101; SrcAE = 32'd99999; SrcBE = 32'd13;
    n = 0; d2 = -1;
    while (d2 < 0 && n < 40) begin
      @(negedge clk);
      if (n == 0) check("b2b_restart_busy", BusyE, 1);
      if (DoneE) begin d2 = n; pulses++; end
      next_cycle();
      n++;
    end
    StartE = 1'b0;
    check("b2b_divu_lat", d2, 33);
    check("b2b_divu_res", ResultE, 32'd99999 / 32'd13);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (DoneE) pulses++;
      next_cycle();
    end
    check("b2b_pulses", pulses, 2);

    // Random operations, biased toward the boundary operands
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      a = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h80000000 : (sel == 2) ? 32'hFFFFFFFF : $urandom;
      sel = $urandom_range(0, 5);
      b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h80000000 : (sel == 2) ? 32'hFFFFFFFF : $urandom;
      op = 3'($urandom_range(0, 7));
      am = ($urandom_range(0, 4) == 0);
      do_op("rand", am, op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
